// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port synchronous RAM between two bus masters.
// Port 0 is normally the processor and port 1 a loader/DMA engine.
// The arbiter grants at most one access per cycle. When both ports
// request, it uses round-robin priority. A port may hold a bounded
// lock for read-modify-write sequences. Read data comes back with the
// RAM's one-cycle latency.
//
// Ports
//   i_clk, i_rst            clock (rising edge), synchronous active-high reset
//   i_req0/1                access request, held by the master until granted
//   i_we0/1                 1 = write, 0 = read
//   i_lock0/1               keep ownership after this transfer
//   i_addr0/1, i_wdata0/1   access address / write data
//   o_gnt0/1                combinational grant; transfer happens at the edge with req & gnt
//   o_rvalid0/1, o_rdata0/1 read return, one cycle after a granted read
//   o_ram_addr/wdata/wren   RAM pins, driven by the granted port
//   i_ram_q                 RAM registered read data
//   o_locked                lock owner: 00 none, 01 port 0, 10 port 1
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no lock; grants are decided by request and round-robin prio
// LOCK0 | port 0 owns the RAM; port 1 is held off until release
// LOCK1 | port 1 owns the RAM; port 0 is held off until release

module mem_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int LOCK_MAX = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    output logic          o_ram_wren,
    input  logic [DW-1:0] i_ram_q,
    output logic [1:0]    o_locked
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LCNT_MAX = CW'(LOCK_MAX);
    localparam logic [CW-1:0] LCNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;       // favoured port on conflict
    logic          w_prio_nxt;
    logic [CW-1:0] r_lcnt;
    logic [CW-1:0] w_lcnt_nxt;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          w_gnt0;
    logic          w_gnt1;

    // Grants. Reset masks them, so nothing reaches the RAM during reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_gnt0 = i_req0 & (~i_req1 | ~r_prio);
                    w_gnt1 = i_req1 & (~i_req0 |  r_prio);
                end
                ST_LOCK0: w_gnt0 = i_req0;
                ST_LOCK1: w_gnt1 = i_req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Next state, priority and lock age.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_lcnt_nxt  = r_lcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt0) begin
                    w_prio_nxt = 1'b1;
                    if (i_lock0) begin
                        w_state_nxt = ST_LOCK0;
                        w_lcnt_nxt  = LCNT_ONE;
                    end
                end else if (w_gnt1) begin
                    w_prio_nxt = 1'b0;
                    if (i_lock1) begin
                        w_state_nxt = ST_LOCK1;
                        w_lcnt_nxt  = LCNT_ONE;
                    end
                end
            end
            ST_LOCK0: begin
                // Release on lock drop or when the hold limit is reached;
                // the counter keeps ageing even if port 0 stops requesting.
                if (!i_lock0 || r_lcnt == LCNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = 1'b1;
                    w_lcnt_nxt  = '0;
                end else begin
                    w_lcnt_nxt = r_lcnt + LCNT_ONE;
                end
            end
            ST_LOCK1: begin
                if (!i_lock1 || r_lcnt == LCNT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_prio_nxt  = 1'b0;
                    w_lcnt_nxt  = '0;
                end else begin
                    w_lcnt_nxt = r_lcnt + LCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_prio    <= 1'b0;
            r_lcnt    <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio    <= w_prio_nxt;
            r_lcnt    <= w_lcnt_nxt;
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
        end
    end

    // RAM pin mux: the granted port drives the pins; otherwise all zero.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_wren  = 1'b0;
        if (w_gnt0) begin
            o_ram_addr  = i_addr0;
            o_ram_wdata = i_wdata0;
            o_ram_wren  = i_we0;
        end else if (w_gnt1) begin
            o_ram_addr  = i_addr1;
            o_ram_wdata = i_wdata1;
            o_ram_wren  = i_we1;
        end
    end

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata0  = i_ram_q;
    assign o_rdata1  = i_ram_q;
    assign o_locked  = {r_state == ST_LOCK1, r_state == ST_LOCK0};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the processor (port 0) and a second bus master such as a loader or DMA engine (port 1). It sits between the requesters and the RAM's address/data/write-enable pins. It grants one access per cycle with round-robin priority on conflict. It supports a bounded bus lock for read-modify-write sequences and returns read data with the RAM's one-cycle latency.

## Interface
- `DW`, 16, data width
- `AW`, 16, address width
- `LOCK_MAX`, 16, maximum consecutive cycles a port may hold the lock (≥1)
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  access request, held until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `lock0`, `lock1`  in  1  request to keep ownership after this transfer
- `addr0`, `addr1`  in  AW  access address
- `wdata0`, `wdata1`  in  DW  write data
- `gnt0`, `gnt1`  out  1  combinational grant; transfer occurs at the edge where `req_k & gnt_k`
- `rvalid0`, `rvalid1`  out  1  read data valid, one cycle after a granted read
- `rdata0`, `rdata1`  out  DW  equal to `ram_q`; meaningful only while `rvalid_k`
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_wren`  out  1  RAM write enable
- `ram_q`  in  DW  RAM registered read data, one cycle after the address edge
- `locked`  out  2  lock owner: 00 none, 01 port 0, 10 port 1

## Operation
- Registered state:
  - FSM state `IDLE` / `LOCK0` / `LOCK1`
  - `prio`, the favoured port on conflict
  - lock counter `lcnt`
  - `rvalid0` and `rvalid1` flops
- Grant logic in `IDLE`:
  - only one requester → that port is granted;
  - both requesting → port `prio` is granted;
  - none requesting → no grant.
- Grant logic in `LOCKk`: `gnt_k = req_k`, and the other port's grant is 0.
- RAM mux: the granted port drives `ram_addr`, `ram_wdata` and `ram_wren = we_k`. With no grant: `ram_addr = 0`, `ram_wdata = 0`, `ram_wren = 0`.
- Priority: after a granted transfer by port k in `IDLE`, `prio` ← other port. On lock exit, `prio` ← the port that did not hold the lock.
- Lock entry: `IDLE` → `LOCKk` at an edge with a granted transfer by k with `lock_k = 1`; `lcnt` ← 1.
- Lock hold: in `LOCKk`, each edge increments `lcnt`.
- Lock exit: `LOCKk` → `IDLE` at the first edge where any of the following holds:
  - `lock_k = 0` (a final transfer by k may occur at that same edge);
  - `lcnt = LOCK_MAX` (forced release, regardless of `lock_k`).
- After a forced release, the other port wins the next conflict through the `prio` rule. A port still holding `lock_k` high may re-enter the lock only via a new granted transfer from `IDLE`.
- Read return: `rvalid_k` ← `req_k & gnt_k & ~we_k`.
- Writes complete at the grant edge; no acknowledge beyond `gnt`.

## Timing
- Reset values (at a `Reset` edge):
  - state `IDLE`, `prio = 0`, `lcnt = 0`;
  - `rvalid0 = rvalid1 = 0`, `locked = 00`.
- While `Reset` is high, `gnt0`, `gnt1` and `ram_wren` are forced to 0.
- Grant latency: 0 cycles. `gnt` follows `req` combinationally in the same cycle.
- Read latency: 1 cycle. `rvalid_k` and `rdata_k` are valid in the cycle after the grant edge.
- Throughput: one transfer per cycle. A single continuous requester is granted every cycle.
- Conflict: two continuous requesters in `IDLE` alternate every cycle.
- Read after write to the same address on consecutive cycles returns the new data (RAM write-first at the edge).
- A requester dropping `req` while in `LOCKk` performs no access; the lock still ages via `lcnt`.
- `Reset` asserted mid-lock:
  - the lock is abandoned and `prio` returns to 0;
  - a read granted in the reset cycle is not performed, and `rvalid` is 0 the next cycle.

## Test plan
- Port 1 writes `0x1234` to `0x0010`; next, port 0 reads `0x0010`.
  - → `gnt0` is high in the request cycle.
  - → `rvalid0 = 1` and `rdata0 = 0x1234` one cycle later.
- After reset, both ports hold `req` high for 6 cycles writing distinct addresses.
  - → grants go 0,1,0,1,0,1.
  - → `ram_wren` is high every cycle.
- Port 1 performs 3 transfers with `lock1 = 1`, then one with `lock1 = 0`, while port 0 requests throughout.
  - → `locked = 10` during the sequence.
  - → `gnt0 = 0` for 4 cycles, then `gnt0 = 1`.
- `LOCK_MAX = 4`: port 1 holds `lock1` and `req1` for 10 cycles while port 0 requests.
  - → forced release after `lcnt = 4`.
  - → the next cycle grants port 0.
- `Reset` pulsed for 1 cycle while in `LOCK1` with both ports requesting.
  - → during the reset cycle, `gnt` is 0 on both ports.
  - → after reset: `locked = 00` and `gnt0 = 1` first (`prio = 0`).
- Port 0 requests alone for 5 back-to-back reads of addresses 0..4 preloaded with `0xA0..0xA4`.
  - → `gnt0` is high for 5 consecutive cycles.
  - → `rvalid0` is high for 5 cycles, delayed by 1, with `rdata0 = 0xA0..0xA4`.
